// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from a sync/blank stream and monitors its timing
//   clk, rst              pixel clock, asynchronous active-high reset
//   hsync, vsync          active-high sync inputs
//   hblnk, vblnk          blanking inputs
//   hcount_rec/vcount_rec recovered position of the previous input sample
//   de                    locked & !hblnk & !vblnk
//   locked                timing locked
//   err_line/err_frame    one-cycle error pulses
//   err_cnt               saturating error count
//   frame_cnt             frames received while locked (wraps)
module vga_sync_decoder #(
   parameter int H_TOTAL      = 1344,
   parameter int H_SYNC_START = 1048,
   parameter int H_SYNC_LEN   = 136,
   parameter int V_TOTAL      = 806,
   parameter int V_SYNC_START = 771,
   parameter int V_SYNC_LEN   = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        hblnk,
   input  logic        vblnk,
   output logic [10:0] hcount_rec,
   output logic [10:0] vcount_rec,
   output logic        de,
   output logic        locked,
   output logic        err_line,
   output logic        err_frame,
   output logic [7:0]  err_cnt,
   output logic [15:0] frame_cnt
);
   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
   localparam logic [10:0] HT  = 11'(H_TOTAL);
   localparam logic [10:0] HSS = 11'(H_SYNC_START);
   localparam logic [10:0] HSL = 11'(H_SYNC_LEN);
   localparam logic [10:0] VT  = 11'(V_TOTAL);
   localparam logic [10:0] VSS = 11'(V_SYNC_START);
   localparam logic [10:0] VSL = 11'(V_SYNC_LEN);
   state_t      st, st_n;
   logic        hs_prev, vs_prev, h_armed;
   logic        hs_rise, hs_fall, vs_rise, vs_fall, h_wrap, e_line, e_frame;
   logic [10:0] h_per, v_per, hc_n, vc_n;
   // h_per: clocks since the last hsync rise, so at the falling edge it is the pulse width.
   // v_per: hsync rises since the last vsync rise, so at the vsync fall it is the pulse width.
   always_comb begin
      hs_rise = hsync & ~hs_prev;
      hs_fall = ~hsync & hs_prev;
      vs_rise = vsync & ~vs_prev;
      vs_fall = ~vsync & vs_prev;
      h_wrap  = ~hs_rise & (hcount_rec == HT - 11'd1);
      hc_n    = hs_rise ? HSS : h_wrap ? '0 : hcount_rec + 11'd1;
      vc_n    = vs_rise ? VSS : !h_wrap ? vcount_rec : (vcount_rec == VT - 11'd1) ? '0 : vcount_rec + 11'd1;
      e_line  = h_armed & ((hs_rise & (h_per != HT)) | (hs_fall & (h_per != HSL)));
      e_frame = (st != SEARCH) & ((vs_rise & (v_per != VT)) | (vs_fall & (v_per != VSL)));
      st_n    = (st == SEARCH) ? (vs_rise ? ACQUIRE : SEARCH) :
                (e_line | e_frame) ? SEARCH : vs_rise ? LOCKED : st;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= SEARCH;
         hs_prev    <= 1'b1;
         vs_prev    <= 1'b1;
         h_armed    <= 1'b0;
         h_per      <= '0;
         v_per      <= '0;
         hcount_rec <= '0;
         vcount_rec <= '0;
         de         <= 1'b0;
         locked     <= 1'b0;
         err_line   <= 1'b0;
         err_frame  <= 1'b0;
         err_cnt    <= '0;
         frame_cnt  <= '0;
      end else begin
         st         <= st_n;
         hs_prev    <= hsync;
         vs_prev    <= vsync;
         h_armed    <= (st_n != SEARCH) & (h_armed | (hs_rise & (st != SEARCH)));
         h_per      <= hs_rise ? 11'd1 : (&h_per) ? h_per : h_per + 11'd1;
         v_per      <= vs_rise ? {10'd0, hs_rise} : (hs_rise & ~&v_per) ? v_per + 11'd1 : v_per;
         hcount_rec <= hc_n;
         vcount_rec <= vc_n;
         locked     <= st_n == LOCKED;
         de         <= (st_n == LOCKED) & ~hblnk & ~vblnk;
         err_line   <= e_line;
         err_frame  <= e_frame;
         err_cnt    <= ((e_line | e_frame) & ~&err_cnt) ? err_cnt + 8'd1 : err_cnt;
         frame_cnt  <= frame_cnt + 16'((st == LOCKED) & (st_n == LOCKED) & vs_rise);
      end
   end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: randomized fault-injection bench with timestamp-based reference model and scoreboard
module tb_vga_sync_decoder;
   localparam int HT = 40, HSS = 30, HSL = 5, VT = 20, VSS = 15, VSL = 3, HACT = 24, VACT = 12;
   logic        clk = 1'b0, rst = 1'b1, hsync = 1'b0, vsync = 1'b0, hblnk = 1'b0, vblnk = 1'b0;
   logic [10:0] hcount_rec, vcount_rec;
   logic        de, locked, err_line, err_frame;
   logic [7:0]  err_cnt;
   logic [15:0] frame_cnt;
   vga_sync_decoder #(
      .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
      .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
   ) dut (
      .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
      .hcount_rec(hcount_rec), .vcount_rec(vcount_rec), .de(de), .locked(locked),
      .err_line(err_line), .err_frame(err_frame), .err_cnt(err_cnt), .frame_cnt(frame_cnt)
   );
   always #5 clk = ~clk;
   typedef struct {
      int hc, vc;
      bit de, lk, el, ef;
      int ec, fc;
   } exp_t;
   exp_t q[$];
   int checks = 0, failures = 0;
   // reference model state: event timestamps and counts rather than counters
   bit m_phs, m_pvs;
   int n = 0, h_anchor, h_base, m_vc, last_hr, cum = 0, cum_vr, stage, l_armed, m_ec, m_fc;
   int mask = 0, rst_left = 0;
   bit rst_q = 1'b1;
   task automatic check(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, req, $time);
      end
   endtask
   function automatic int sat(input int x);
      return x > 2047 ? 2047 : x;
   endfunction
   task automatic model_reset();
      m_phs = 1'b1; m_pvs = 1'b1;
      h_anchor = n - 1; h_base = 0; m_vc = 0;
      stage = 0; l_armed = 0; m_ec = 0; m_fc = 0;
      last_hr = 0; cum_vr = 0;
   endtask
   task automatic model_step(input bit hs, input bit vs, input bit hb, input bit vb);
      bit hr, hf, vr, vf;
      int hc, el, ef, ns;
      hr = hs && !m_phs; hf = !hs && m_phs;
      vr = vs && !m_pvs; vf = !vs && m_pvs;
      if (hr) begin h_anchor = n; h_base = HSS; end
      hc = (h_base + n - h_anchor) % HT;
      if (vr) m_vc = VSS;
      else if (!hr && hc == 0) m_vc = (m_vc + 1) % VT;
      el = (l_armed != 0 && ((hr && sat(n - last_hr) != HT) || (hf && sat(n - last_hr) != HSL))) ? 1 : 0;
      ef = (stage != 0 && ((vr && sat(cum - cum_vr) != VT) || (vf && sat(cum - cum_vr) != VSL))) ? 1 : 0;
      if (stage == 0) ns = vr ? 1 : 0;
      else if (el != 0 || ef != 0) ns = 0;
      else ns = vr ? 2 : stage;
      if (stage == 2 && ns == 2 && vr) m_fc = (m_fc + 1) % 65536;
      l_armed = (ns != 0 && (l_armed != 0 || (hr && stage != 0))) ? 1 : 0;
      if (el != 0 || ef != 0) m_ec = (m_ec == 255) ? 255 : m_ec + 1;
      stage = ns;
      if (hr) last_hr = n;
      if (vr) cum_vr = cum;
      if (hr) cum++;
      q.push_back('{hc, m_vc, (ns == 2 && !hb && !vb), (ns == 2), el[0], ef[0], m_ec, m_fc});
      m_phs = hs; m_pvs = vs;
      n++;
   endtask
   task automatic tick(input bit hs, input bit vs, input bit hb, input bit vb, input bit r);
      @(negedge clk);
      rst = r; hsync = hs; vsync = vs; hblnk = hb; vblnk = vb;
      if (r) begin
         if (!rst_q) begin
            #1;
            check("async_rst_hcount", hcount_rec, 0);
            check("async_rst_vcount", vcount_rec, 0);
            check("async_rst_locked", locked, 0);
            check("async_rst_de", de, 0);
            check("async_rst_err_cnt", err_cnt, 0);
            check("async_rst_frame_cnt", frame_cnt, 0);
         end
         model_reset();
         q.push_back('{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
      end else model_step(hs, vs, hb, vb);
      rst_q = r;
   endtask
   // kinds: 0 nominal, 1 short line, 2 narrow hsync, 3 short frame, 4 hsync stuck low,
   // 5 reset mid-frame, 6 wide vsync, 7 long line
   task automatic run_frame(input int kind);
      int fl, fc_, len, w, vsl;
      bit r;
      fl  = int'($urandom_range(1, VT - 2));
      fc_ = int'($urandom_range(0, HT - 2));
      vsl = VSL + ((kind == 6) ? 1 : 0);
      for (int v = (kind == 3) ? 1 : 0; v < VT; v++) begin
         len = HT + ((kind == 1 && v == fl) ? -1 : (kind == 7 && v == fl) ? 1 : 0);
         w = HSL - ((kind == 2 && v == fl) ? 1 : 0);
         for (int h = 0; h < len; h++) begin
            if (kind == 4 && v == fl && h == 0) mask = 2100;
            if (kind == 5 && v == fl && h == fc_) rst_left = 3;
            r = rst_left > 0;
            if (rst_left > 0) rst_left--;
            tick((h >= HSS && h < HSS + w) && mask == 0, v >= VSS && v < VSS + vsl, h >= HACT, v >= VACT, r);
            if (mask > 0) mask--;
         end
      end
   endtask
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("hcount_rec", hcount_rec, e.hc);
            check("vcount_rec", vcount_rec, e.vc);
            check("de", de, e.de);
            check("locked", locked, e.lk);
            check("err_line", err_line, e.el);
            check("err_frame", err_frame, e.ef);
            check("err_cnt", err_cnt, e.ec);
            check("frame_cnt", frame_cnt, e.fc);
         end
      end
   end
   initial begin : stim
      model_reset();
      repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (4) run_frame(0);
      @(posedge clk);
      #1;
      check("nominal_locked", locked, 1);
      check("nominal_frame_cnt", frame_cnt, 2);
      check("nominal_err_cnt", err_cnt, 0);
      for (int k = 1; k <= 7; k++) begin
         run_frame(k);
         repeat (3) run_frame(0);
      end
      repeat (6) begin
         run_frame(int'($urandom_range(1, 7)));
         repeat (3) run_frame(0);
      end
      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
